// File: rtl/wb_arbiter.sv
// wb_arbiter - two-master round-robin arbiter for a Wishbone B4 pipelined bus.
// Master m0 (SPI-controlled) and master m1 share one slave bus. The grant is taken
// one clock after cyc is seen in IDLE and is held until the owner drops cyc.
// Optional watchdog: define WB_ARBITER_TIMEOUT_EN to abort bus cycles that a
// slave never acknowledges (limit set by TIMEOUT, in clocks).
module wb_arbiter #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  // master 0
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [DAT_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADR_WIDTH-1:0]   m0_adr_i,
  input  logic [DAT_WIDTH-1:0]   m0_dat_i,
  output logic [DAT_WIDTH-1:0]   m0_dat_o,
  output logic                   m0_stall_o,
  output logic                   m0_ack_o,
  // master 1
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [DAT_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADR_WIDTH-1:0]   m1_adr_i,
  input  logic [DAT_WIDTH-1:0]   m1_dat_i,
  output logic [DAT_WIDTH-1:0]   m1_dat_o,
  output logic                   m1_stall_o,
  output logic                   m1_ack_o,
  // shared slave bus
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [DAT_WIDTH/8-1:0] s_sel_o,
  output logic [ADR_WIDTH-1:0]   s_adr_o,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  input  logic                   s_stall_i,
  input  logic                   s_ack_i
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // Per-master views packed into arrays so both masters share one code path.
  logic [1:0]           w_m_cyc;
  logic [1:0]           w_m_stb;
  logic [1:0]           w_m_we;
  logic [1:0]           w_m_ack;
  logic [1:0]           w_m_stall;
  logic [SEL_WIDTH-1:0] w_m_sel  [2];
  logic [ADR_WIDTH-1:0] w_m_adr  [2];
  logic [DAT_WIDTH-1:0] w_m_wdat [2];
  logic [DAT_WIDTH-1:0] w_m_rdat [2];

  assign w_m_cyc     = {m1_cyc_i, m0_cyc_i};
  assign w_m_stb     = {m1_stb_i, m0_stb_i};
  assign w_m_we      = {m1_we_i, m0_we_i};
  assign w_m_sel[0]  = m0_sel_i;
  assign w_m_sel[1]  = m1_sel_i;
  assign w_m_adr[0]  = m0_adr_i;
  assign w_m_adr[1]  = m1_adr_i;
  assign w_m_wdat[0] = m0_dat_i;
  assign w_m_wdat[1] = m1_dat_i;

  // Arbitration state and round-robin pointer (index of the last master granted).
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_last_gnt;
  logic       w_last_gnt_next;
  logic       w_gnt_valid;
  logic       w_gnt_idx;

  assign w_gnt_valid = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_gnt_idx   = (r_state == ST_GNT1);

  // Watchdog outputs: w_to_hit is the single abort cycle, w_force masks the
  // slave-side strobes from that cycle until the owner releases the bus.
  logic w_to_hit;
  logic w_force;

  // Next grant: ties go to the master that was not served last. The pointer is
  // moved on every grant so a lone requester does not win the following tie.
  always_comb begin
    w_state_next    = r_state;
    w_last_gnt_next = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (r_last_gnt) begin
            w_state_next    = ST_GNT0;
            w_last_gnt_next = 1'b0;
          end else begin
            w_state_next    = ST_GNT1;
            w_last_gnt_next = 1'b1;
          end
        end else if (m0_cyc_i) begin
          w_state_next    = ST_GNT0;
          w_last_gnt_next = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_next    = ST_GNT1;
          w_last_gnt_next = 1'b1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) w_state_next = ST_IDLE;
      end
      ST_GNT1: begin
        if (!m1_cyc_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset leaves m0 as the winner of the first tie.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_last_gnt <= w_last_gnt_next;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_timed_out;
  logic                 w_cur_stb;

  assign w_cur_stb = w_m_stb[w_gnt_idx];
  assign w_to_hit  = w_gnt_valid && !r_timed_out && (r_cnt == CNT_WIDTH'(TIMEOUT));
  assign w_force   = w_to_hit || r_timed_out;

  // Idle-clock counter: any slave progress restarts it; once it fires, the
  // abort state is held until the owner drops cyc and the arbiter returns to IDLE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else if (!w_gnt_valid) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else if (r_timed_out) begin
      r_cnt       <= r_cnt;
    end else if (w_to_hit) begin
      r_timed_out <= 1'b1;
    end else if (s_ack_i || (w_cur_stb && !s_stall_i)) begin
      r_cnt       <= '0;
    end else begin
      r_cnt       <= r_cnt + CNT_WIDTH'(1);
    end
  end
`else
  // Without the watchdog a silent slave keeps the grant indefinitely.
  logic w_timeout_unused;

  assign w_timeout_unused = (TIMEOUT > 0);
  assign w_to_hit         = 1'b0;
  assign w_force          = 1'b0;
`endif

  // Slave-side mux: the owner's signals pass straight through, IDLE drives zeros.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (w_gnt_valid) begin
      s_cyc_o = w_m_cyc[w_gnt_idx] & ~w_force;
      s_stb_o = w_m_stb[w_gnt_idx] & ~w_force;
      s_we_o  = w_m_we[w_gnt_idx];
      s_sel_o = w_m_sel[w_gnt_idx];
      s_adr_o = w_m_adr[w_gnt_idx];
      s_dat_o = w_m_wdat[w_gnt_idx];
    end
  end

  // Master-side returns: the owner sees the slave's handshake, the waiting
  // master is stalled on its own strobe so its request stays pending.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic w_owner;

    assign w_owner       = w_gnt_valid && (w_gnt_idx == 1'(gi));
    assign w_m_ack[gi]   = w_owner ? (w_to_hit | (s_ack_i & ~w_force)) : 1'b0;
    assign w_m_stall[gi] = w_owner ? (s_stall_i | w_force) : w_m_stb[gi];
    assign w_m_rdat[gi]  = (w_owner && w_to_hit) ? {DAT_WIDTH{1'b1}} : s_dat_i;
  end

  assign m0_ack_o   = w_m_ack[0];
  assign m1_ack_o   = w_m_ack[1];
  assign m0_stall_o = w_m_stall[0];
  assign m1_stall_o = w_m_stall[1];
  assign m0_dat_o   = w_m_rdat[0];
  assign m1_dat_o   = w_m_rdat[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter - directed scenarios followed by random traffic for wb_arbiter,
// every cycle checked against an ownership-level reference model.
// Define WB_ARBITER_TIMEOUT_EN to build the watchdog variant (TIMEOUT=8).
`timescale 1ns/1ps
module tb_wb_arbiter;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [15:0] adr [2];
  logic [31:0] wdat [2];
  logic [31:0] mdat [2];
  logic        stall_o [2];
  logic        ack_o [2];
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [15:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat;
  logic        s_stall, s_ack;

  wb_arbiter #(.ADR_WIDTH(16), .DAT_WIDTH(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(mdat[0]),
    .m0_stall_o(stall_o[0]), .m0_ack_o(ack_o[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(mdat[1]),
    .m1_stall_o(stall_o[1]), .m1_ack_o(ack_o[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
    .s_stall_i(s_stall), .s_ack_i(s_ack)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (-1 = nobody), round-robin memory, watchdog.
  int          own;
  bit          last;
  int          cnt;
  bit          tout;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_cnt [2];
  logic [31:0] last_ack_dat [2];
  int          dut_grants [$];
  logic        prev_scyc = 1'b0;
  int          held [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own  = -1;
    last = 1'b1;
    cnt  = 0;
    tout = 1'b0;
  endtask

  // Compare every output with what the model says the bus should look like now.
  task automatic check_outputs();
    bit          hit, frc;
    logic        e_ack, e_stall;
    logic [31:0] e_dat;
    #1;
    hit = TO_EN && (own >= 0) && !tout && (cnt == TO);
    frc = hit || tout;
    if (own >= 0) begin
      chk("s_cyc", s_cyc_o, cyc[own] && !frc);
      chk("s_stb", s_stb_o, stb[own] && !frc);
      chk("s_we", s_we_o, we[own]);
      chk("s_sel", s_sel_o, sel[own]);
      chk("s_adr", s_adr_o, adr[own]);
      chk("s_dat", s_dat_o, wdat[own]);
    end else begin
      chk("s_cyc_idle", s_cyc_o, 1'b0);
      chk("s_stb_idle", s_stb_o, 1'b0);
      chk("s_we_idle", s_we_o, 1'b0);
    end
    for (int m = 0; m < 2; m++) begin
      if (own == m) begin
        e_ack   = hit ? 1'b1 : (frc ? 1'b0 : s_ack);
        e_stall = frc ? 1'b1 : s_stall;
        e_dat   = hit ? 32'hFFFF_FFFF : s_dat;
      end else begin
        e_ack   = 1'b0;
        e_stall = stb[m];
        e_dat   = s_dat;
      end
      chk($sformatf("m%0d_ack", m), ack_o[m], e_ack);
      chk($sformatf("m%0d_stall", m), stall_o[m], e_stall);
      chk($sformatf("m%0d_dat", m), mdat[m], e_dat);
      if (ack_o[m] === 1'b1) begin
        ack_cnt[m]++;
        last_ack_dat[m] = mdat[m];
      end
    end
    if (s_cyc_o === 1'b1 && prev_scyc !== 1'b1)
      dut_grants.push_back((s_adr_o == adr[1]) ? 1 : 0);
    prev_scyc = s_cyc_o;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (own < 0) begin
        if (cyc[0] && cyc[1]) own = last ? 0 : 1;
        else if (cyc[0])      own = 0;
        else if (cyc[1])      own = 1;
        if (own >= 0) last = (own == 1);
        cnt  = 0;
        tout = 1'b0;
      end else if (!cyc[own]) begin
        own  = -1;
        cnt  = 0;
        tout = 1'b0;
      end else if (TO_EN && !tout) begin
        if (cnt == TO)                             tout = 1'b1;
        else if (s_ack || (stb[own] && !s_stall))  cnt = 0;
        else                                       cnt++;
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_outputs();
    tick();
  endtask

  task automatic clear_counts();
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    last_ack_dat[0] = '0;
    last_ack_dat[1] = '0;
    dut_grants.delete();
  endtask

  task automatic idle_masters();
    for (int m = 0; m < 2; m++) begin
      cyc[m] = 1'b0;
      stb[m] = 1'b0;
      we[m]  = 1'b0;
    end
    s_ack   = 1'b0;
    s_stall = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      cyc[m] = 0; stb[m] = 0; we[m] = 0; sel[m] = 4'hF; adr[m] = '0; wdat[m] = '0;
    end
    s_dat = '0; s_stall = 0; s_ack = 0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;

    // Reset state: nothing forwarded, a loose strobe is stalled, a stray ack is ignored.
    stb[0] = 1'b1;
    cycle();
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    stb[0] = 1'b0;
    rst_n = 1'b1;
    cycle();
    chk("reset_acks", ack_cnt[0] + ack_cnt[1], 0);

    // 1: m0 single read at 0x0010, slave acks 3 clocks after the strobe.
    clear_counts();
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0010; sel[0] = 4'hF;
    cycle();                       // IDLE, grant pending
    cycle();                       // GNT0, strobe accepted
    stb[0] = 0;
    cycle();
    cycle();
    s_ack = 1; s_dat = 32'h1234_5678;
    cycle();
    s_ack = 0; s_dat = 32'h0BAD_0BAD; cyc[0] = 0;
    cycle();
    cycle();
    $display("t1 m0 read: acks=%0d dat=%h m1_acks=%0d", ack_cnt[0], last_ack_dat[0], ack_cnt[1]);
    chk("t1_m0_acks", ack_cnt[0], 1);
    chk("t1_m0_dat", last_ack_dat[0], 32'h1234_5678);
    chk("t1_m1_acks", ack_cnt[1], 0);

    // 2: both masters request in the same clock right after reset.
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
    clear_counts();
    adr[0] = 16'h0A00; adr[1] = 16'h0B00;
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
    cycle();                       // IDLE
    cycle();                       // GNT0, m1 stalled
    stb[0] = 0; s_ack = 1;
    cycle();
    s_ack = 0; cyc[0] = 0;
    cycle();                       // release
    cycle();                       // mandatory IDLE
    cycle();                       // GNT1
    stb[1] = 0; s_ack = 1;
    cycle();
    s_ack = 0; cyc[1] = 0;
    cycle();
    cycle();
    $display("t2 tie after reset: grants=%p", dut_grants);
    chk("t2_grant_count", dut_grants.size(), 2);
    if (dut_grants.size() >= 2) begin
      chk("t2_first_grant", dut_grants[0], 0);
      chk("t2_second_grant", dut_grants[1], 1);
    end
    chk("t2_acks", {ack_cnt[0][15:0], ack_cnt[1][15:0]}, {16'd1, 16'd1});

    // 3: both masters re-request continuously; grants must alternate.
    clear_counts();
    held[0] = 0; held[1] = 0;
    for (int i = 0; i < 60 && dut_grants.size() < 6; i++) begin
      s_ack = 0;
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) begin
          cyc[m] = 1; stb[m] = 1; held[m] = 0;
        end else if (own == m) begin
          if (held[m] == 1) begin
            stb[m] = 0; s_ack = 1;
          end else if (held[m] == 2) begin
            cyc[m] = 0;
          end
          held[m]++;
        end
      end
      cycle();
    end
    $display("t3 alternation: grants=%p acks0=%0d acks1=%0d", dut_grants, ack_cnt[0], ack_cnt[1]);
    chk("t3_grant_count", dut_grants.size(), 6);
    for (int k = 0; k < dut_grants.size() && k < 6; k++)
      chk($sformatf("t3_grant%0d", k), dut_grants[k], k % 2);
    chk("t3_m0_acks", ack_cnt[0], 3);
    chk("t3_m1_acks", ack_cnt[1], 2);
    idle_masters();
    cycle();
    cycle();

    // 4: m1 write 0xCAFEF00D with the slave stalling for 2 clocks.
    clear_counts();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = 16'h0044; wdat[1] = 32'hCAFE_F00D;
    cycle();                       // IDLE
    s_stall = 1;
    cycle();
    cycle();
    s_stall = 0;
    chk("t4_s_dat_pre", s_dat_o, 32'hCAFE_F00D);
    cycle();                       // accepted
    stb[1] = 0; s_ack = 1;
    cycle();
    s_ack = 0; cyc[1] = 0;
    cycle();
    cycle();
    $display("t4 m1 write: acks=%0d", ack_cnt[1]);
    chk("t4_m1_acks", ack_cnt[1], 1);
    chk("t4_m0_acks", ack_cnt[0], 0);
    we[1] = 0;

    // 5: asynchronous reset in the middle of a granted read.
    clear_counts();
    cyc[0] = 1; stb[0] = 1; adr[0] = 16'h0020;
    cycle();
    cycle();
    stb[0] = 0;
    cycle();
    #3;
    chk("t5_pre_s_cyc", s_cyc_o, 1'b1);
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    $display("t5 async reset: s_cyc=%b m0_ack=%b", s_cyc_o, ack_o[0]);
    chk("t5_s_cyc", s_cyc_o, 1'b0);
    chk("t5_m0_ack", ack_o[0], 1'b0);
    chk("t5_m0_stall", stall_o[0], stb[0]);
    model_reset();
    s_ack = 0;
    idle_masters();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

`ifdef WB_ARBITER_TIMEOUT_EN
    // 6: slave accepts the strobe but never acks; the watchdog aborts.
    clear_counts();
    cyc[0] = 1; stb[0] = 1; adr[0] = 16'h0030;
    cycle();
    cycle();
    stb[0] = 0;
    for (int i = 0; i < 20; i++) cycle();
    $display("t6 timeout: acks=%0d dat=%h s_cyc=%b", ack_cnt[0], last_ack_dat[0], s_cyc_o);
    chk("t6_m0_acks", ack_cnt[0], 1);
    chk("t6_m0_dat", last_ack_dat[0], 32'hFFFF_FFFF);
    chk("t6_s_cyc_held_low", s_cyc_o, 1'b0);
    cyc[0] = 0;
    cycle();
    cycle();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) begin
          cyc[m] = ($urandom % 3 == 0);
          stb[m] = cyc[m] & $urandom;
          we[m]  = $urandom;
          sel[m] = 4'($urandom);
          adr[m] = 16'($urandom);
          wdat[m] = $urandom;
        end else if (own == m) begin
          stb[m] = $urandom;
          we[m]  = $urandom;
          sel[m] = 4'($urandom);
          adr[m] = 16'($urandom);
          wdat[m] = $urandom;
          if ($urandom % 5 == 0) begin
            cyc[m] = 0;
            stb[m] = 0;
          end
        end
      end
      s_stall = ($urandom % 3 == 0);
      s_ack   = ($urandom % 3 == 0);
      s_dat   = $urandom;
      cycle();
      if (i % 50 == 0) $display("rnd %0d: own=%0d s_cyc=%b", i, own, s_cyc_o);
    end
    idle_masters();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
